// File: rtl/myiic_readbyte_if.sv
`default_nettype none
// ============================================================================
// Module      : myiic_readbyte_if
// Description : Caller-side signal bundle of the IIC byte receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface myiic_readbyte_if;
  logic       en_read;
  logic       ack_send;
  logic       scl;
  logic       sda_dir;
  logic [7:0] data;
  logic       busy;
  logic       done;

  modport master (
    output en_read, ack_send,
    input  scl, sda_dir, data, busy, done
  );

  modport slave (
    input  en_read, ack_send,
    output scl, sda_dir, data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/myiic_readbyte.sv
`default_nettype none
// ============================================================================
// Module      : myiic_readbyte
// Description : IIC master byte receiver; clocks in 8 bits MSB first, then
//               drives ACK/NACK on the 9th bit.
// Revision    : 1.0 - initial release
// ============================================================================
module myiic_readbyte #(
  parameter int QTR = 125
) (
  input  wire              clk,
  input  wire              rst_n,
  myiic_readbyte_if.slave  bus,
  inout  wire              sda
);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_RX_BIT  = 2'd1;
  localparam logic [1:0] c_ST_ACK_BIT = 2'd2;
  localparam logic [1:0] c_ST_FIN     = 2'd3;

  localparam int                  c_QCNT_W    = (QTR > 2) ? $clog2(QTR) : 1;
  localparam logic [c_QCNT_W-1:0] c_QCNT_LAST = c_QCNT_W'(QTR - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;
  logic [c_QCNT_W-1:0] r_qcnt;
  logic [1:0]          r_phase;
  logic [2:0]          r_bitcnt;
  logic [7:0]          r_shift;
  logic [7:0]          r_data;
  logic                r_ack;
  logic                r_sda_val;

  logic                w_qtr_end;
  logic                w_bit_end;
  logic                w_scl;
  logic                w_sda_dir;
  logic                w_busy;
  logic                w_done;

  assign w_qtr_end = (r_qcnt == c_QCNT_LAST);
  assign w_bit_end = w_qtr_end && (r_phase == 2'd3);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (bus.en_read) begin
          w_next_state = c_ST_RX_BIT;
        end
      end
      c_ST_RX_BIT: begin
        if (w_bit_end && (r_bitcnt == 3'd0)) begin
          w_next_state = c_ST_ACK_BIT;
        end
      end
      c_ST_ACK_BIT: begin
        if (w_bit_end) begin
          w_next_state = c_ST_FIN;
        end
      end
      c_ST_FIN: begin
        w_next_state = c_ST_IDLE;
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  // Output logic: SCL high only in the two middle quarters of each bit
  always_comb begin
    w_scl     = 1'b0;
    w_sda_dir = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      c_ST_RX_BIT: begin
        w_busy = 1'b1;
        w_scl  = (r_phase == 2'd1) || (r_phase == 2'd2);
      end
      c_ST_ACK_BIT: begin
        w_busy    = 1'b1;
        w_sda_dir = 1'b1;
        w_scl     = (r_phase == 2'd1) || (r_phase == 2'd2);
      end
      c_ST_FIN: begin
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Bit timing, shift register and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qcnt    <= '0;
      r_phase   <= 2'd0;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_ack     <= 1'b0;
      r_sda_val <= 1'b1;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.en_read) begin
            r_ack    <= bus.ack_send;
            r_shift  <= 8'h00;
            r_qcnt   <= '0;
            r_phase  <= 2'd0;
            r_bitcnt <= 3'd7;
          end
        end
        c_ST_RX_BIT, c_ST_ACK_BIT: begin
          if (w_qtr_end) begin
            r_qcnt  <= '0;
            r_phase <= r_phase + 2'd1;
          end else begin
            r_qcnt <= r_qcnt + c_QCNT_W'(1);
          end
          if (r_state == c_ST_RX_BIT) begin
            // Sample mid-high, on the last clock of phase 1
            if (w_qtr_end && (r_phase == 2'd1)) begin
              r_shift <= {r_shift[6:0], sda};
            end
            if (w_bit_end) begin
              r_bitcnt <= r_bitcnt - 3'd1;
              if (r_bitcnt == 3'd0) begin
                r_sda_val <= ~r_ack;
              end
            end
          end else if (w_bit_end) begin
            // Publish on entry to FIN so done and data appear together
            r_data    <= r_shift;
            r_sda_val <= 1'b1;
          end
        end
        default: begin
          r_qcnt <= '0;
        end
      endcase
    end
  end

  assign bus.scl     = w_scl;
  assign bus.sda_dir = w_sda_dir;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.data    = r_data;

  assign sda = w_sda_dir ? r_sda_val : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_myiic_readbyte.sv
`default_nettype none
// ============================================================================
// Module      : tb_myiic_readbyte
// Description : Randomized self-checking bench for myiic_readbyte with an
//               IIC slave transmitter model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_myiic_readbyte;

  localparam int QTR  = 4;
  localparam int BYTE = 36 * QTR;
  localparam int WIN  = BYTE + 8;

  logic clk = 1'b0;
  logic rst_n;
  wire  sda;

  myiic_readbyte_if bus ();

  myiic_readbyte #(.QTR(QTR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .sda   (sda)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Slave transmitter: presents the next bit after every SCL fall
  logic [7:0] tx_byte = 8'h00;
  int         rx_idx  = 0;
  logic       scl_q   = 1'b0;
  logic       slave_bit;

  always @(negedge clk) begin
    scl_q <= bus.scl;
    if (!bus.busy) begin
      rx_idx <= 0;
    end else if (scl_q && !bus.scl) begin
      rx_idx <= rx_idx + 1;
    end
  end

  always_comb begin
    slave_bit = 1'b1;
    if (rx_idx < 8) begin
      slave_bit = tx_byte[3'(7 - rx_idx)];
    end
  end

  assign sda = bus.sda_dir ? 1'bz : slave_bit;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One byte from accept; tog_k > 0 pulses en_read mid-byte
  task automatic run_byte(input logic [7:0] b, input logic ack, input int tog_k);
    int         done_cnt  = 0;
    int         done_k    = 0;
    int         pulses    = 0;
    int         run       = 0;
    int         bad_w     = 0;
    int         dir_cnt   = 0;
    int         dir_first = 0;
    int         sda_bad   = 0;
    int         busy_bad  = 0;
    logic [7:0] d_done    = 8'h00;
    tx_byte = b;
    @(negedge clk);
    en_read_drv(1'b1);
    bus.ack_send = ack;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (k == 1) begin
        en_read_drv(1'b0);
        bus.ack_send = ~ack;
      end
      if (tog_k > 0 && k == tog_k)     en_read_drv(1'b1);
      if (tog_k > 0 && k == tog_k + 3) en_read_drv(1'b0);
      if (bus.scl) begin
        run++;
      end else if (run > 0) begin
        pulses++;
        if (run != 2 * QTR) bad_w++;
        run = 0;
      end
      if (bus.sda_dir) begin
        dir_cnt++;
        if (dir_first == 0) dir_first = k;
        if (sda !== ~ack) sda_bad++;
      end
      if (bus.busy !== (k <= BYTE)) busy_bad++;
      if (bus.done) begin
        done_cnt++;
        done_k = k;
        d_done = bus.data;
      end
    end
    check_val("done_count", done_cnt, 1);
    check_val("done_latency", done_k, BYTE + 1);
    check_val("data", {24'h0, d_done}, {24'h0, b});
    check_val("scl_pulses", pulses, 9);
    check_val("scl_width_err", bad_w, 0);
    check_val("dir_cycles", dir_cnt, 4 * QTR);
    check_val("dir_start", dir_first, 32 * QTR + 1);
    check_val("ack_sda_err", sda_bad, 0);
    check_val("busy_err", busy_bad, 0);
    check_val("data_hold", {24'h0, bus.data}, {24'h0, b});
  endtask

  task automatic en_read_drv(input logic v);
    bus.en_read = v;
  endtask

  task automatic run_b2b();
    int         dk[$];
    logic [7:0] dd[$];
    logic       idle_scl  = 1'bx;
    logic       idle_busy = 1'bx;
    tx_byte = 8'h01;
    @(negedge clk);
    bus.en_read  = 1'b1;
    bus.ack_send = 1'b1;
    for (int k = 1; k <= 2 * (BYTE + 2) + 6; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dk.push_back(k);
        dd.push_back(bus.data);
        if (dk.size() == 1) tx_byte = 8'hFE;
        else bus.en_read = 1'b0;
      end
      if (k == BYTE + 2) begin
        idle_scl  = bus.scl;
        idle_busy = bus.busy;
      end
    end
    check_val("b2b_count", dk.size(), 2);
    while (dk.size() < 2) begin
      dk.push_back(-1000);
      dd.push_back(8'hxx);
    end
    check_val("b2b_first_k", dk[0], BYTE + 1);
    check_val("b2b_spacing", dk[1] - dk[0], BYTE + 2);
    check_val("b2b_data0", {24'h0, dd[0]}, 32'h01);
    check_val("b2b_data1", {24'h0, dd[1]}, 32'hFE);
    check_val("b2b_idle_scl", {31'h0, idle_scl}, 0);
    check_val("b2b_idle_busy", {31'h0, idle_busy}, 0);
    bus.en_read = 1'b0;
    repeat (BYTE + 4) @(negedge clk);
  endtask

  task automatic run_reset_mid();
    int done_seen = 0;
    tx_byte = 8'($urandom);
    @(negedge clk);
    bus.en_read  = 1'b1;
    bus.ack_send = 1'b1;
    for (int k = 1; k <= 16 * QTR + 2; k++) begin
      @(negedge clk);
      if (k == 1) bus.en_read = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_val("rst_scl", {31'h0, bus.scl}, 0);
    check_val("rst_dir", {31'h0, bus.sda_dir}, 0);
    check_val("rst_busy", {31'h0, bus.busy}, 0);
    check_val("rst_data", {24'h0, bus.data}, 0);
    repeat (4) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (BYTE) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check_val("rst_no_done", done_seen, 0);
  endtask

  initial begin
    logic [7:0] rb;
    logic       ra;
    int         rt;
    rst_n        = 1'b0;
    bus.en_read  = 1'b0;
    bus.ack_send = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_scl", {31'h0, bus.scl}, 0);
    check_val("reset_dir", {31'h0, bus.sda_dir}, 0);
    check_val("reset_busy", {31'h0, bus.busy}, 0);
    check_val("reset_done", {31'h0, bus.done}, 0);
    check_val("reset_data", {24'h0, bus.data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_byte(8'hA5, 1'b1, 0);
    run_byte(8'h3C, 1'b0, 0);
    run_b2b();
    run_byte(8'($urandom), 1'b0, 12 * QTR + 1);
    run_reset_mid();
    run_byte(8'h80, 1'b1, 0);
    run_byte(8'h00, 1'b0, 0);
    run_byte(8'hFF, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      ra = 1'($urandom);
      rt = ($urandom % 2 == 0) ? 0 : int'($urandom_range(2, BYTE - 4));
      run_byte(rb, ra, rt);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
